btn_debounce: RTL
=================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter STABLE_CNT, default 1000000, number of consecutive clk cycles the synchronized input must hold a new level before it is accepted (10 ms at 100 MHz); legal range 2..2^24.
REQ-002 Parameter CNT_W, default ceil(log2(STABLE_CNT)), width of the internal stability counter.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_in  input  1  raw mechanical switch/button level, asynchronous to clk, may bounce.
REQ-006 db_level  output  1  debounced, registered level of btn_in.
REQ-007 rise_tick  output  1  registered one-cycle pulse when db_level goes 0->1; feeds the downstream dflop-based edge/one-shot stage.
REQ-008 fall_tick  output  1  registered one-cycle pulse when db_level goes 1->0.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer; only the second flop output (sync_in) feeds the FSM.
REQ-010 The FSM SHALL have four states: LOW (stable 0), WAIT_HI (candidate 1), HIGH (stable 1), WAIT_LO (candidate 0).
REQ-011 LOW: sync_in=1 -> WAIT_HI with cnt cleared to 0; otherwise stay.
REQ-012 WAIT_HI: sync_in=0 -> LOW, no output change; sync_in=1 and cnt==STABLE_CNT-1 -> HIGH; else cnt increments.
REQ-013 HIGH: sync_in=0 -> WAIT_LO with cnt cleared to 0; otherwise stay.
REQ-014 WAIT_LO: sync_in=1 -> HIGH, no output change; sync_in=0 and cnt==STABLE_CNT-1 -> LOW; else cnt increments.
REQ-015 db_level SHALL be 1 exactly in HIGH and WAIT_LO, registered, never glitching.
REQ-016 rise_tick SHALL be 1 for exactly the single cycle following the WAIT_HI->HIGH transition edge; fall_tick likewise for WAIT_LO->LOW; never both high.
REQ-017 Latency: a clean btn_in step first sampled at edge k SHALL change db_level and pulse the tick after edge k+STABLE_CNT+2.
REQ-018 Any bounce returning sync_in to the accepted level during WAIT_* SHALL abort the attempt; the next attempt restarts cnt from 0.
REQ-019 cnt SHALL never exceed STABLE_CNT-1 and SHALL NOT wrap; cnt is don't-care in LOW/HIGH.
REQ-020 Back-to-back accepted changes SHALL be separated by at least STABLE_CNT+1 cycles.

Reset
REQ-021 rst SHALL asynchronously force state LOW, cnt 0, both synchronizer flops 0, db_level 0, rise_tick 0, fall_tick 0.
REQ-022 Reset mid-WAIT_* SHALL discard the pending candidate; with btn_in held 1 through release, db_level SHALL rise STABLE_CNT+3 edges after release, with one rise_tick.
REQ-023 No output SHALL pulse on the first edge after reset release.

Structure
REQ-024 State encoding (LOW, WAIT_HI, HIGH, WAIT_LO) and default STABLE_CNT SHALL live in a shared package used by debounce/one-shot stages.
REQ-025 The synchronizer SHALL be a sub-module, sync_2ff (clk, rst, d, q), reset value 0.
REQ-026 All outputs SHALL be flop outputs; no combinational path from btn_in to any output.

Verification (STABLE_CNT=4)
REQ-027 Reset, btn_in held 0 for 20 cycles -> db_level 0, no ticks.
REQ-028 btn_in 0->1 sampled at edge 1, held -> db_level 1 after edge 7, rise_tick high only the cycle after edge 7.
REQ-029 btn_in 1 for 3 cycles, 0 for 1, then 1 held -> no change until edge 7 after the final rise is sampled; exactly one rise_tick.
REQ-030 From HIGH, btn_in 1->0 held -> db_level 0 after 7 edges, one fall_tick, rise_tick stays 0.
REQ-031 btn_in toggling every cycle for 40 cycles -> db_level constant, zero ticks.
REQ-032 rst asserted 2 cycles into WAIT_HI, btn_in held 1 -> outputs 0 immediately; db_level 1 seven edges after rst release, single rise_tick.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button debounce and downstream one-shot stages:
// state encoding, default stability window and the output payload.
package btn_debounce_pkg;

    localparam int unsigned DB_STABLE_CNT_DEFAULT = 32'd1000000;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_WAIT_LO = 2'd3
    } db_state_e;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } db_out_t;

    // Accepted level is 1 while stable high or while a drop is still unconfirmed.
    function automatic logic db_level_of(input db_state_e st);
        return (st == ST_HIGH) || (st == ST_WAIT_LO);
    endfunction

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous button level into the clk
// domain; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces a raw button level: a new level is accepted only after the
// synchronized input holds it through a full stability window.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = DB_STABLE_CNT_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(STABLE_CNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 32'd1);

    logic          sync_in;
    db_state_e     state_q;
    db_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    db_out_t       out_q;
    db_out_t       out_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync_in)
    );

    // Candidate tracking; a bounce back to the accepted level aborts the attempt.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_d      = '0;

        unique case (state_q)
            ST_LOW: begin
                if (sync_in) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HI: begin
                if (!sync_in) begin
                    state_d = ST_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_HIGH;
                    out_d.rise = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!sync_in) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LO: begin
                if (sync_in) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_LOW;
                    out_d.fall = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase

        out_d.level = db_level_of(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign db_level  = out_q.level;
    assign rise_tick = out_q.rise;
    assign fall_tick = out_q.fall;

endmodule
